// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one fixed-latency signed divider among N_REQ
// requesters. Each issued operation carries its requester tag and a
// zero-divisor flag through a tracker so the quotient can be routed back to
// the requester that issued it. HOLD_OPS selects between a single in-flight
// operation with operands held stable, and a fully pipelined tracker.
module div_arbiter #(
    parameter int N_REQ    = 4,
    parameter int A_W      = 9,
    parameter int B_W      = 9,
    parameter int O_W      = 20,
    parameter int DIV_LAT  = 3,
    parameter int HOLD_OPS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*A_W-1:0]     req_a,
    input  logic [N_REQ*B_W-1:0]     req_b,
    output logic signed [A_W-1:0]    div_a,
    output logic signed [B_W-1:0]    div_b,
    input  logic signed [O_W-1:0]    div_o,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic signed [O_W-1:0]    rsp_o,
    output logic                     rsp_dz,
    output logic                     busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (DIV_LAT > 0) ? $clog2(DIV_LAT + 1) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Arbitration and issue signals
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]        grant_idx;
    logic                    grant_found;
    logic                    can_issue;
    logic                    accept;
    logic signed [A_W-1:0]   grant_a;
    logic signed [B_W-1:0]   grant_b;

    // Operand registers toward the divider
    logic signed [A_W-1:0]   div_a_q, div_a_d;
    logic signed [B_W-1:0]   div_b_q, div_b_d;

    // Capture interface from whichever tracker is built
    logic                    capture;
    logic [PTR_W-1:0]        cap_tag;
    logic                    cap_dz;

    // Response registers
    logic [N_REQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic signed [O_W-1:0]   rsp_o_q, rsp_o_d;
    logic                    rsp_dz_q, rsp_dz_d;

    // Round-robin search: first set request at or above the pointer, wrapping
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        grant_a = '0;
        grant_b = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (PTR_W'(k) == grant_idx) begin
                grant_a = req_a[k*A_W +: A_W];
                grant_b = req_b[k*B_W +: B_W];
            end
        end
    end

    assign accept    = grant_found & can_issue;
    assign req_ready = accept ? onehot(grant_idx) : '0;

    // Pointer moves past the winner only on an accepted handshake
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (grant_idx == PTR_W'(N_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + 1'b1;
            end
        end
    end

    generate
        if (HOLD_OPS != 0) begin : g_hold
            // One operation in flight; the counter times the divider latency
            state_t             state_q, state_d;
            logic [CNT_W-1:0]   cnt_q, cnt_d;
            logic [PTR_W-1:0]   tag_q, tag_d;
            logic               dz_q, dz_d;

            assign can_issue = (state_q == S_IDLE);

            // Next-state: start on accept, capture when the countdown expires
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                tag_d   = tag_q;
                dz_d    = dz_q;
                capture = 1'b0;
                case (state_q)
                    S_IDLE: begin
                        if (accept) begin
                            state_d = S_WAIT;
                            cnt_d   = CNT_W'(DIV_LAT);
                            tag_d   = grant_idx;
                            dz_d    = (grant_b == '0);
                        end
                    end
                    S_WAIT: begin
                        if (cnt_q == '0) begin
                            capture = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end

            // State, countdown and tag registers
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    tag_q   <= '0;
                    dz_q    <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    tag_q   <= tag_d;
                    dz_q    <= dz_d;
                end
            end

            assign cap_tag = tag_q;
            assign cap_dz  = dz_q;
            assign busy    = (state_q == S_WAIT);
        end else begin : g_pipe
            // Shift register of DIV_LAT+1 stages; the last stage is the one
            // whose quotient is on div_o right now
            logic [DIV_LAT:0]   vld_q, vld_d;
            logic [DIV_LAT:0]   dz_q, dz_d;
            logic [PTR_W-1:0]   tag_q [DIV_LAT+1];
            logic [PTR_W-1:0]   tag_d [DIV_LAT+1];

            assign can_issue = 1'b1;

            // Advance every in-flight entry one stage per cycle
            always_comb begin
                vld_d    = {vld_q[DIV_LAT-1:0], accept};
                dz_d     = {dz_q[DIV_LAT-1:0], (grant_b == '0)};
                tag_d[0] = grant_idx;
                for (int k = 1; k <= DIV_LAT; k++) begin
                    tag_d[k] = tag_q[k-1];
                end
            end

            // Tracker registers
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    dz_q  <= '0;
                    for (int k = 0; k <= DIV_LAT; k++) begin
                        tag_q[k] <= '0;
                    end
                end else begin
                    vld_q <= vld_d;
                    dz_q  <= dz_d;
                    for (int k = 0; k <= DIV_LAT; k++) begin
                        tag_q[k] <= tag_d[k];
                    end
                end
            end

            assign capture = vld_q[DIV_LAT];
            assign cap_tag = tag_q[DIV_LAT];
            assign cap_dz  = dz_q[DIV_LAT];
            assign busy    = |vld_q;
        end
    endgenerate

    // Operand and response next values; operands and quotient hold otherwise
    always_comb begin
        div_a_d     = accept ? grant_a : div_a_q;
        div_b_d     = accept ? grant_b : div_b_q;
        rsp_valid_d = capture ? onehot(cap_tag) : '0;
        rsp_o_d     = capture ? div_o : rsp_o_q;
        rsp_dz_d    = capture ? cap_dz : rsp_dz_q;
    end

    // Pointer, operand and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            rsp_valid_q <= '0;
            rsp_o_q     <= '0;
            rsp_dz_q    <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_o_q     <= rsp_o_d;
            rsp_dz_q    <= rsp_dz_d;
        end
    end

    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_o     = rsp_o_q;
    assign rsp_dz    = rsp_dz_q;

endmodule
